fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning byte address of first fetch after reset.
REQ-002 SHALL have parameter QDEPTH, default 2, meaning fetch-queue entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port imem_addr  output  `WIDTH-2  word address to InstructionMemory (pc[`WIDTH-1:2]).
REQ-006 SHALL have port imem_data  input  `WIDTH  instruction word returned combinationally for imem_addr.
REQ-007 SHALL have port redirect_valid  input  1  branch/jump taken; flush and restart at redirect_pc.
REQ-008 SHALL have port redirect_pc  input  `WIDTH  new byte PC.
REQ-009 SHALL have port inst_valid  output  1  queue head holds a valid instruction.
REQ-010 SHALL have port inst_ready  input  1  decode accepts the head this cycle.
REQ-011 SHALL have port inst_data  output  `WIDTH  head instruction word.
REQ-012 SHALL have port inst_pc  output  `WIDTH  byte PC of head instruction.
REQ-013 SHALL have port misalign_err  output  1  redirect target not word-aligned (FETCH_ALIGN_CHK_EN only).

Function
REQ-014 SHALL drive imem_addr combinationally from the pc register every cycle.
REQ-015 SHALL enqueue {pc, imem_data} and advance pc by 4 at a posedge when fetch_en = !redirect_valid && (!full || (inst_valid && inst_ready)).
REQ-016 SHALL dequeue the head at a posedge when inst_valid && inst_ready; enqueue and dequeue in the same cycle SHALL both occur, count unchanged.
REQ-017 SHALL hold pc and queue contents when full and inst_ready low; no instruction dropped or duplicated.
REQ-018 SHALL drive inst_valid = (count != 0); inst_data/inst_pc SHALL hold the head entry while inst_valid && !inst_ready.
REQ-019 On redirect_valid at a posedge SHALL empty the queue, discard any same-cycle enqueue, and load pc <= {redirect_pc[`WIDTH-1:2],2'b00}; redirect has priority over dequeue.
REQ-020 Latency: instruction at redirect target SHALL appear with inst_valid high one cycle after the redirect edge.
REQ-021 pc SHALL wrap modulo 2^`WIDTH (32'hFFFFFFFC + 4 -> 32'h0); queue pointers SHALL wrap modulo QDEPTH.
REQ-022 inst_valid SHALL be low in the cycle after a redirect, regardless of prior queue state.

Reset
REQ-023 While rst_n low: pc = RESET_PC, queue empty, inst_valid = 0, inst_data = 0, inst_pc = 0, misalign_err = 0.
REQ-024 Reset asserted mid-operation SHALL clear state immediately (asynchronously), discarding queued instructions.
REQ-025 First enqueue SHALL occur at the first posedge after rst_n rises; inst_valid high after that edge with inst_pc = RESET_PC.

Configuration
REQ-026 With FETCH_ALIGN_CHK_EN defined, redirect with redirect_pc[1:0] != 0 SHALL set misalign_err for exactly one cycle after the edge and still redirect to the truncated aligned PC.
REQ-027 Without FETCH_ALIGN_CHK_EN, misalign_err SHALL be tied 0 and no check logic built.

Structure
REQ-028 `WIDTH, `IMEM_LEN and the default reset PC constant SHALL come from the shared Parameters.v; no local redefinition.
REQ-029 Queue SHALL be a separate sub-module fetch_queue (synchronous FIFO, flush input, count/full/empty outputs).

Verification
REQ-030 Reset release, inst_ready=1, memory holding 0x11111111,0x22222222 at 0x0,0x4 -> inst_pc 0x0 then 0x4 on consecutive cycles, data matching.
REQ-031 inst_ready=0 for 5 cycles -> queue fills to 2, pc frozen at 0x8, imem_addr=2; release -> 0x0,0x4,0x8 delivered in order, none lost.
REQ-032 redirect_valid with redirect_pc=0x40 while queue full -> next cycle inst_valid=0, following cycle inst_pc=0x40.
REQ-033 pc forced near top: redirect to 0xFFFFFFFC -> instructions at 0xFFFFFFFC then 0x0.
REQ-034 rst_n pulsed low mid-stream (queue 1 entry) -> inst_valid drops asynchronously; after release inst_pc=RESET_PC.
REQ-035 FETCH_ALIGN_CHK_EN defined, redirect_pc=0x42 -> misalign_err one cycle, next inst_pc=0x40.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// Module : fetch_unit_pkg
// Desc   : Shared fetch parameters (WIDTH, IMEM_LEN, RESET_PC_DEFAULT) and the
//          fetch-queue entry type. Optional macro: FETCH_ALIGN_CHK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef IMEM_LEN
`define IMEM_LEN 256
`endif
`ifndef RESET_PC_DEFAULT
`define RESET_PC_DEFAULT 32'h0000_0000
`endif

package fetch_unit_pkg;

    localparam int unsigned C_INST_BYTES = 4;

    typedef struct packed {
        logic [`WIDTH-1:0] pc;
        logic [`WIDTH-1:0] inst;
    } fetch_entry_t;

    function automatic logic [`WIDTH-1:0] pc_incr(input logic [`WIDTH-1:0] pc);
        return pc + `WIDTH'(C_INST_BYTES);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module : fetch_queue
// Desc   : Synchronous FIFO with flush and count/full/empty status.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int DW    = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            push_data,
    output logic [DW-1:0]            head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CW'(DEPTH));
    assign count     = r_count;
    assign head_data = empty ? '0 : r_mem[r_rd_ptr];

    // A push into a full queue is legal when the head leaves on the same edge.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module : fetch_unit
// Desc   : Instruction fetch: PC register, imem addressing, fetch queue,
//          redirect handling. Optional macro: FETCH_ALIGN_CHK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [`WIDTH-1:0] RESET_PC = `RESET_PC_DEFAULT,
    parameter int                QDEPTH   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [`WIDTH-3:0]   imem_addr,
    input  logic [`WIDTH-1:0]   imem_data,
    input  logic                redirect_valid,
    input  logic [`WIDTH-1:0]   redirect_pc,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [`WIDTH-1:0]   inst_data,
    output logic [`WIDTH-1:0]   inst_pc,
    output logic                misalign_err
);

    logic [`WIDTH-1:0]       r_pc;
    logic                    w_fetch_en;
    logic                    w_deq;
    logic                    w_q_full;
    logic                    w_q_empty_unused;
    logic [$clog2(QDEPTH):0] w_q_count;
    fetch_entry_t            w_push_entry;
    fetch_entry_t            w_head_entry;

    assign imem_addr  = r_pc[`WIDTH-1:2];
    assign inst_valid = (w_q_count != '0);
    assign inst_data  = w_head_entry.inst;
    assign inst_pc    = w_head_entry.pc;

    // Redirect outranks both fetch and dequeue: the queue is flushed instead.
    assign w_deq      = inst_valid && inst_ready && !redirect_valid;
    assign w_fetch_en = !redirect_valid && (!w_q_full || (inst_valid && inst_ready));

    assign w_push_entry.pc   = r_pc;
    assign w_push_entry.inst = imem_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= {redirect_pc[`WIDTH-1:2], 2'b00};
        end else if (w_fetch_en) begin
            r_pc <= pc_incr(r_pc);
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH),
        .DW    ($bits(fetch_entry_t))
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (w_fetch_en),
        .pop       (w_deq),
        .push_data (w_push_entry),
        .head_data (w_head_entry),
        .count     (w_q_count),
        .full      (w_q_full),
        .empty     (w_q_empty_unused)
    );

`ifdef FETCH_ALIGN_CHK_EN
    logic r_misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
        end
    end

    assign misalign_err = r_misalign;
`else
    logic [1:0] w_unused_pc_lsbs;

    assign w_unused_pc_lsbs = redirect_pc[1:0];
    assign misalign_err     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module : tb_fetch_unit
// Desc   : Self-checking bench for fetch_unit (queue-level reference model).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          QDEPTH   = 2;

    logic        clk;
    logic        rst_n;
    logic [29:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        misalign_err;

    int errors = 0;
    int checks = 0;

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .QDEPTH   (QDEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .misalign_err   (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        if (a == 30'd0) return 32'h1111_1111;
        if (a == 30'd1) return 32'h2222_2222;
        return 32'hC0DE_0000 ^ {a, 2'b11};
    endfunction

    assign imem_data = mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: list of queued PCs plus the next fetch PC.
    logic [31:0] mq[$];
    logic [31:0] mpc   = RESET_PC;
    logic        m_mis = 1'b0;
    logic        m_acc;
    logic        m_room;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mpc   = RESET_PC;
            m_mis = 1'b0;
        end else begin
`ifdef FETCH_ALIGN_CHK_EN
            m_mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
            m_mis = 1'b0;
`endif
            if (redirect_valid) begin
                mq.delete();
                mpc = {redirect_pc[31:2], 2'b00};
            end else begin
                m_acc  = (mq.size() > 0) && inst_ready;
                m_room = (mq.size() < QDEPTH) || m_acc;
                if (m_acc) void'(mq.pop_front());
                if (m_room) begin
                    mq.push_back(mpc);
                    mpc = mpc + 32'd4;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("imem_addr", {2'b00, imem_addr}, {2'b00, mpc[31:2]});
        chk("inst_valid", {31'd0, inst_valid}, {31'd0, mq.size() != 0});
        if (mq.size() != 0) begin
            chk("inst_pc", inst_pc, mq[0]);
            chk("inst_data", inst_data, mem_word(mq[0][31:2]));
        end else if (!rst_n) begin
            chk("rst_inst_pc", inst_pc, 32'd0);
            chk("rst_inst_data", inst_data, 32'd0);
        end
        chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
    end

    task automatic edge_wait(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    logic [19:0] ready_pat = 20'b1011_0011_1000_1101_0110;

    initial begin
        rst_n          = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;

        edge_wait(3);
        chk("L_rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("L_rst_pc", inst_pc, 32'd0);
        chk("L_rst_data", inst_data, 32'd0);
        chk("L_rst_mis", {31'd0, misalign_err}, 32'd0);
        chk("L_rst_addr", {2'b00, imem_addr}, 32'd0);

        // Stream from reset with decode always ready.
        rst_n      = 1'b1;
        inst_ready = 1'b1;
        edge_wait(1);
        chk("L_first_valid", {31'd0, inst_valid}, 32'd1);
        chk("L_first_pc", inst_pc, 32'h0);
        chk("L_first_data", inst_data, 32'h1111_1111);
        edge_wait(1);
        chk("L_second_pc", inst_pc, 32'h4);
        chk("L_second_data", inst_data, 32'h2222_2222);

        // Asynchronous reset with one entry queued.
        #1 rst_n = 1'b0;
        #1 chk("L_async_valid", {31'd0, inst_valid}, 32'd0);
        edge_wait(1);
        rst_n      = 1'b1;
        inst_ready = 1'b0;
        edge_wait(1);
        chk("L_rel_pc", inst_pc, RESET_PC);

        // Back-pressure: queue fills, pc freezes.
        edge_wait(4);
        chk("L_stall_addr", {2'b00, imem_addr}, 32'd2);
        chk("L_stall_pc", inst_pc, 32'h0);
        inst_ready = 1'b1;
        edge_wait(1);
        chk("L_drain_pc4", inst_pc, 32'h4);
        edge_wait(1);
        chk("L_drain_pc8", inst_pc, 32'h8);

        // Redirect while full.
        inst_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        edge_wait(1);
        redirect_valid = 1'b0;
        chk("L_redir_bubble", {31'd0, inst_valid}, 32'd0);
        edge_wait(1);
        chk("L_redir_valid", {31'd0, inst_valid}, 32'd1);
        chk("L_redir_pc", inst_pc, 32'h40);
        chk("L_redir_data", inst_data, 32'hC0DE_0000 ^ 32'h43);

        // Wrap at top of address space.
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        edge_wait(1);
        redirect_valid = 1'b0;
        chk("L_wrap_bubble", {31'd0, inst_valid}, 32'd0);
        edge_wait(1);
        chk("L_wrap_top", inst_pc, 32'hFFFF_FFFC);
        edge_wait(1);
        chk("L_wrap_zero", inst_pc, 32'h0);

        // Irregular decode back-pressure, checked by the model each cycle.
        for (int i = 0; i < 20; i++) begin
            inst_ready = ready_pat[i];
            edge_wait(1);
        end

        // Misaligned redirect target.
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        edge_wait(1);
        redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
        chk("L_mis_set", {31'd0, misalign_err}, 32'd1);
`else
        chk("L_mis_set", {31'd0, misalign_err}, 32'd0);
`endif
        edge_wait(1);
        chk("L_mis_clear", {31'd0, misalign_err}, 32'd0);
        chk("L_mis_pc", inst_pc, 32'h40);

        edge_wait(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
